// File: rtl/lut_cfg_loader.sv
// rtl/lut_cfg_loader.sv - serial LUT configuration loader with atomic shadow-to-active commit
module lut_cfg_loader #(
    parameter int NUM_LUTS = 4,
    parameter int CFG_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      cfg_valid,
    input  logic                      cfg_bit,
    output logic                      cfg_ready,
    output logic [NUM_LUTS*CFG_W-1:0] lut_config,
    output logic                      busy,
    output logic                      done,
    output logic                      loaded
);
    localparam int TOT   = NUM_LUTS * CFG_W;
    localparam int CNT_W = $clog2(TOT) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TOT-1:0]   shadow_q, shadow_d;
    logic [TOT-1:0]   lut_config_q, lut_config_d;
    logic             done_q, done_d;
    logic             loaded_q, loaded_d;
    logic             accept;

    // Handshake signals decode from the state register only.
    assign cfg_ready  = (state_q == SHIFT);
    assign busy       = (state_q != IDLE);
    assign accept     = cfg_valid && cfg_ready;
    assign lut_config = lut_config_q;
    assign done       = done_q;
    assign loaded     = loaded_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shadow_d     = shadow_q;
        lut_config_d = lut_config_q;
        done_d       = 1'b0;
        loaded_d     = loaded_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    count_d = '0;
                end
            end
            SHIFT: begin
                // Abort wins over a simultaneous accept, even the final bit.
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    shadow_d = {shadow_q[TOT-2:0], cfg_bit};
                    count_d  = count_q + 1'b1;
                    if (count_q == CNT_W'(TOT - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (!abort) begin
                    lut_config_d = shadow_q;
                    loaded_d     = 1'b1;
                    done_d       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shadow_q     <= '0;
            lut_config_q <= '0;
            done_q       <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
            lut_config_q <= lut_config_d;
            done_q       <= done_d;
            loaded_q     <= loaded_d;
        end
    end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb/tb_lut_cfg_loader.sv - randomized self-checking bench for lut_cfg_loader
module tb_lut_cfg_loader;
    localparam int NUM_LUTS = 4;
    localparam int CFG_W    = 16;
    localparam int TOT      = NUM_LUTS * CFG_W;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_bit = 1'b0;
    logic           cfg_ready;
    logic [TOT-1:0] lut_config;
    logic           busy;
    logic           done;
    logic           loaded;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the active config and loaded flag must be.
    logic [TOT-1:0] exp_cfg    = '0;
    logic           exp_loaded = 1'b0;

    lut_cfg_loader #(.NUM_LUTS(NUM_LUTS), .CFG_W(CFG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .lut_config (lut_config),
        .busy       (busy),
        .done       (done),
        .loaded     (loaded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stall_mode: 0 none, 1 every other cycle, 2 random.
    // abort_at: -1 none, 0..TOT-1 abort on the cycle bit abort_at is offered, TOT abort in COMMIT.
    task automatic do_load(input logic [TOT-1:0] data, input int stall_mode, input int abort_at,
                           input bit start_noise, input bit abort_with_start, input string name);
        int i = 0;
        int stalls = 0;
        int edges = 0;
        bit st;
        bit phase = 1'b1;
        logic [TOT-1:0] prev = exp_cfg;
        start = 1'b1;
        abort = abort_with_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s start: busy=%b cfg_ready=%b done=%b expected 1 1 0", name, busy, cfg_ready, done);
        end
        while (i < TOT) begin
            if (stall_mode == 1) st = phase;
            else if (stall_mode == 2) st = ($urandom_range(0, 3) == 0);
            else st = 1'b0;
            phase = ~phase;
            cfg_valid = !st;
            cfg_bit = st ? 1'($urandom) : data[TOT-1-i];
            if (start_noise) start = 1'($urandom);
            if (abort_at == i && !st) abort = 1'b1;
            tick();
            edges++;
            if (abort) begin
                abort = 1'b0;
                cfg_valid = 1'b0;
                start = 1'b0;
                checks++;
                if (busy !== 1'b0 || cfg_ready !== 1'b0 || lut_config !== prev || done !== 1'b0 || loaded !== exp_loaded) begin
                    failures++;
                    $display("FAIL %s abort_shift: busy=%b ready=%b cfg=%h done=%b loaded=%b expected 0 0 %h 0 %b",
                             name, busy, cfg_ready, lut_config, done, loaded, prev, exp_loaded);
                end
                tick();
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s abort_no_done: done=%b expected 0", name, done);
                end
                return;
            end
            if (st) stalls++;
            else i++;
            if (i < TOT) begin
                checks++;
                if (cfg_ready !== 1'b1 || lut_config !== prev || done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s shift bit %0d: ready=%b cfg=%h done=%b expected 1 %h 0", name, i, cfg_ready, lut_config, done, prev);
                end
            end
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1 || lut_config !== prev || done !== 1'b0) begin
            failures++;
            $display("FAIL %s commit_state: ready=%b busy=%b cfg=%h done=%b expected 0 1 %h 0", name, cfg_ready, busy, lut_config, done, prev);
        end
        if (abort_at == TOT) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            checks++;
            if (busy !== 1'b0 || lut_config !== prev || done !== 1'b0 || loaded !== exp_loaded) begin
                failures++;
                $display("FAIL %s abort_commit: busy=%b cfg=%h done=%b loaded=%b expected 0 %h 0 %b", name, busy, lut_config, done, loaded, prev, exp_loaded);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s abort_commit_no_done: done=%b expected 0", name, done);
            end
            return;
        end
        tick();
        edges++;
        exp_cfg = data;
        exp_loaded = 1'b1;
        checks++;
        if (lut_config !== exp_cfg || done !== 1'b1 || busy !== 1'b0 || loaded !== 1'b1 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s commit: cfg=%h done=%b busy=%b loaded=%b ready=%b expected %h 1 0 1 0", name, lut_config, done, busy, loaded, cfg_ready, exp_cfg);
        end
        checks++;
        if (edges != TOT + 1 + stalls) begin
            failures++;
            $display("FAIL %s latency: edges=%0d expected %0d", name, edges, TOT + 1 + stalls);
        end
    endtask

    task automatic check_done_low(input string name);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || lut_config !== exp_cfg) begin
            failures++;
            $display("FAIL %s done_pulse: done=%b busy=%b cfg=%h expected 0 0 %h", name, done, busy, lut_config, exp_cfg);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        tick();
        tick();
        checks++;
        if (lut_config !== '0 || busy !== 1'b0 || cfg_ready !== 1'b0 || done !== 1'b0 || loaded !== 1'b0) begin
            failures++;
            $display("FAIL reset: cfg=%h busy=%b ready=%b done=%b loaded=%b expected all zero", lut_config, busy, cfg_ready, done, loaded);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_ignored();
        for (int k = 0; k < 6; k++) begin
            cfg_valid = 1'b1;
            cfg_bit = 1'($urandom);
            abort = 1'($urandom);
            tick();
            checks++;
            if (cfg_ready !== 1'b0 || busy !== 1'b0 || lut_config !== exp_cfg || done !== 1'b0) begin
                failures++;
                $display("FAIL idle_ignored: ready=%b busy=%b cfg=%h done=%b expected 0 0 %h 0", cfg_ready, busy, lut_config, done, exp_cfg);
            end
        end
        cfg_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_full_load();
        do_load(64'hFFFE_8000_6996_0001, 0, -1, 1'b0, 1'b0, "full_load");
        check_done_low("full_load");
    endtask

    task automatic test_stalled();
        do_load({$urandom, $urandom}, 0, -1, 1'b0, 1'b0, "pre_stall");
        check_done_low("pre_stall");
        do_load(64'hFFFE_8000_6996_0001, 1, -1, 1'b0, 1'b0, "stalled");
        check_done_low("stalled");
    endtask

    task automatic test_abort();
        do_load({$urandom, $urandom}, 0, 30, 1'b0, 1'b0, "abort30");
        do_load(64'h0, 0, -1, 1'b0, 1'b0, "load_zero");
        check_done_low("load_zero");
        do_load({$urandom, $urandom}, 0, -1, 1'b0, 1'b0, "pre_edge");
        do_load({$urandom, $urandom}, 2, TOT - 1, 1'b0, 1'b0, "abort_last_bit");
        do_load({$urandom, $urandom}, 2, TOT, 1'b0, 1'b0, "abort_commit");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            do_load({$urandom, $urandom}, 2, -1, 1'b1, 1'b0, "back_to_back");
        end
        check_done_low("back_to_back");
        do_load({$urandom, $urandom}, 0, -1, 1'b0, 1'b1, "start_abort_idle");
        check_done_low("start_abort_idle");
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cfg_valid = 1'b1;
            cfg_bit = 1'($urandom);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        exp_cfg = '0;
        exp_loaded = 1'b0;
        checks++;
        if (lut_config !== '0 || busy !== 1'b0 || cfg_ready !== 1'b0 || loaded !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: cfg=%h busy=%b ready=%b loaded=%b done=%b expected all zero", lut_config, busy, cfg_ready, loaded, done);
        end
        cfg_valid = 1'b0;
        #3 rst = 1'b0;
        tick();
        do_load({$urandom, $urandom}, 2, -1, 1'b0, 1'b0, "after_reset");
        check_done_low("after_reset");
    endtask

    initial begin
        test_reset();
        test_idle_ignored();
        test_full_load();
        test_stalled();
        test_abort();
        test_back_to_back();
        test_idle_ignored();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end
endmodule
